// File: rtl/hex_display_reader.sv
// Scans a multiplexed active-low 7-segment bus one digit at a time, decodes each glyph
// back to a hex nibble and reports a reading once enough consecutive scans agree.
module hex_display_reader #(
  parameter int NUM_DIGITS   = 6,
  parameter int SETTLE       = 3,
  parameter int STABLE_SCANS = 2,
  parameter int MAX_SCANS    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [6:0]              seg_in,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    timeout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SETTLE + 2);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam int SW = $clog2(MAX_SCANS + 1);
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [MW-1:0] STABLE_C = MW'(STABLE_SCANS);
  localparam logic [SW-1:0] MAX_C    = SW'(MAX_SCANS);

  typedef enum logic [1:0] {IDLE, SCAN, CHECK, DONE} state_t;

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   cur_val, st_val;
  logic [NUM_DIGITS-1:0]        cur_err, st_err;
  logic [DW-1:0]                dig;
  logic [CW-1:0]                cnt;
  logic [MW-1:0]                match_cnt, match_next;
  logic [SW-1:0]                scans_done, scans_next;
  logic [4:0]                   enc;
  logic                         same, stable, exhausted, stepping;

  // {err, nibble}; unknown patterns (including blank) decode as nibble 0 with err set
  function automatic logic [4:0] encode(input logic [6:0] s);
    case (s)
      7'h40: encode = 5'h00;
      7'h79: encode = 5'h01;
      7'h24: encode = 5'h02;
      7'h30: encode = 5'h03;
      7'h19: encode = 5'h04;
      7'h12: encode = 5'h05;
      7'h02: encode = 5'h06;
      7'h78: encode = 5'h07;
      7'h00: encode = 5'h08;
      7'h10: encode = 5'h09;
      7'h08: encode = 5'h0A;
      7'h03: encode = 5'h0B;
      7'h46: encode = 5'h0C;
      7'h21: encode = 5'h0D;
      7'h06: encode = 5'h0E;
      7'h0E: encode = 5'h0F;
      default: encode = 5'h10;
    endcase
  endfunction

  always_comb begin
    enc        = encode(seg_in);
    same       = (scans_done != '0) && (cur_val == st_val) && (cur_err == st_err);
    match_next = same ? match_cnt + 1'b1 : MW'(1);
    scans_next = scans_done + 1'b1;
    stable     = (match_next == STABLE_C);
    exhausted  = (scans_next == MAX_C);
    // CHECK doubles as the first settle cycle of digit 0 when another scan follows
    stepping   = (state == SCAN) || ((state == CHECK) && !stable && !exhausted);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_val    <= '0;
      cur_err    <= '0;
      st_val     <= '0;
      st_err     <= '0;
      dig        <= '0;
      cnt        <= '0;
      match_cnt  <= '0;
      scans_done <= '0;
      digit_sel  <= '0;
      value      <= '0;
      digit_err  <= '0;
      timeout    <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (stepping) begin
        if (cnt == SETTLE_C) begin
          cur_val[dig] <= enc[3:0];
          cur_err[dig] <= enc[4];
          cnt          <= '0;
          if (dig == LAST_DIG) begin
            state     <= CHECK;
            dig       <= '0;
            digit_sel <= NUM_DIGITS'(1);
          end else begin
            state     <= SCAN;
            dig       <= dig + 1'b1;
            digit_sel <= digit_sel << 1;
          end
        end else begin
          state <= SCAN;
          cnt   <= cnt + 1'b1;
        end
      end

      case (state)
        IDLE: if (start) begin
          state      <= SCAN;
          busy       <= 1'b1;
          digit_sel  <= NUM_DIGITS'(1);
          dig        <= '0;
          cnt        <= '0;
          match_cnt  <= '0;
          scans_done <= '0;
        end
        CHECK: begin
          st_val     <= cur_val;
          st_err     <= cur_err;
          match_cnt  <= match_next;
          scans_done <= scans_next;
          if (stable || exhausted) begin
            state     <= DONE;
            digit_sel <= '0;
            value     <= cur_val;
            digit_err <= cur_err;
            timeout   <= !stable;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
